// File: rtl/rx_funcmod_if.sv
// Serial receiver bus: line and enable in, received byte, done pulse and framing flag out.
interface rx_funcmod_if;
  logic       RXD;
  logic       iCall;
  logic       oDone;
  logic [7:0] oData;
  logic       oErr;

  modport master (output RXD, output iCall, input oDone, input oData, input oErr);
  modport slave  (input RXD, input iCall, output oDone, output oData, output oErr);
endinterface

// File: rtl/rx_funcmod.sv
// 8N1 UART receiver: mid-bit sampling timed from the synchronized start edge,
// one-cycle done pulse, byte and framing flag held between frames.
module rx_funcmod #(
  parameter logic [8:0] B115K2 = 9'd434,
  parameter logic [8:0] HALF   = 9'd217
) (
  input  logic        CLOCK,
  input  logic        RESET,
  rx_funcmod_if.slave bus
);

  typedef enum logic [2:0] {HUNT, START, DATA, STOP, DONE} state_t;

  state_t     state, state_n;
  logic       sync_a, sync_b, sync_prev;
  logic [8:0] c1, c1_n;
  logic [3:0] bidx, bidx_n;
  logic [7:0] shift, shift_n;
  logic [7:0] data_q, data_n;
  logic       err_q, err_n;
  logic       sample;

  // sync_b is the only view of the line the FSM uses; sync_prev gives the edge
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      sync_a    <= 1'b1;
      sync_b    <= 1'b1;
      sync_prev <= 1'b1;
      state     <= HUNT;
      c1        <= 9'd0;
      bidx      <= 4'd0;
      shift     <= 8'h00;
      data_q    <= 8'h00;
      err_q     <= 1'b0;
    end else begin
      sync_a    <= bus.RXD;
      sync_b    <= sync_a;
      sync_prev <= sync_b;
      state     <= state_n;
      c1        <= c1_n;
      bidx      <= bidx_n;
      shift     <= shift_n;
      data_q    <= data_n;
      err_q     <= err_n;
    end
  end

  // Start-bit sample lands HALF clocks after the edge, every later one a full bit apart
  assign sample = (state == START) ? (c1 == HALF - 9'd1) : (c1 == B115K2 - 9'd1);

  always_comb begin
    state_n = state;
    c1_n    = c1 + 9'd1;
    bidx_n  = bidx;
    shift_n = shift;
    data_n  = data_q;
    err_n   = err_q;
    case (state)
      HUNT: begin
        c1_n   = 9'd0;
        bidx_n = 4'd0;
        if (bus.iCall && sync_prev && !sync_b)
          state_n = START;
      end
      START: begin
        if (sample) begin
          c1_n    = 9'd0;
          state_n = sync_b ? HUNT : DATA;
        end
      end
      DATA: begin
        if (sample) begin
          c1_n                = 9'd0;
          shift_n[bidx[2:0]]  = sync_b;
          bidx_n              = bidx + 4'd1;
          if (bidx == 4'd7)
            state_n = STOP;
        end
      end
      STOP: begin
        if (sample) begin
          c1_n    = 9'd0;
          bidx_n  = bidx + 4'd1;
          data_n  = shift;
          err_n   = ~sync_b;
          state_n = DONE;
        end
      end
      DONE: begin
        c1_n    = 9'd0;
        state_n = HUNT;
      end
      default: begin
        c1_n    = 9'd0;
        state_n = HUNT;
      end
    endcase
    // Dropping iCall abandons the frame, but a completed frame always reports
    if (!bus.iCall && state != DONE) begin
      state_n = HUNT;
      c1_n    = 9'd0;
      bidx_n  = 4'd0;
      data_n  = data_q;
      err_n   = err_q;
    end
  end

  assign bus.oDone = (state == DONE);
  assign bus.oData = data_q;
  assign bus.oErr  = err_q;

endmodule

// File: tb/tb_rx_funcmod.sv
// Directed bench for rx_funcmod: hand-built 8N1 frames, done pulses logged on the falling edge.
module tb_rx_funcmod;
  localparam int BIT = 434;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   fall_cyc = 0;
  logic [7:0] seen_data [$];
  logic       seen_err  [$];

  rx_funcmod_if bus ();

  rx_funcmod #(.B115K2(9'd434), .HALF(9'd217)) dut (
    .CLOCK (clk),
    .RESET (rst),
    .bus   (bus.slave)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.oDone) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
      seen_data.push_back(bus.oData);
      seen_err.push_back(bus.oErr);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests = tests + 1;
    if (got !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at a negedge with the line high
  task automatic send_byte(input logic [7:0] d, input logic stopb);
    bus.RXD = 1'b0;
    fall_cyc = cyc;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      bus.RXD = d[i];
      idle(BIT);
    end
    bus.RXD = stopb;
    idle(BIT);
    bus.RXD = 1'b1;
  endtask

  int n0;

  initial begin
    bus.RXD   = 1'b1;
    bus.iCall = 1'b1;
    idle(3);
    check("reset_done", {31'd0, bus.oDone}, 32'd0);
    check("reset_data", {24'd0, bus.oData}, 32'h00);
    check("reset_err",  {31'd0, bus.oErr},  32'd0);
    rst = 1'b0;
    idle(20);

    // Basic frame and its latency from the line edge
    send_byte(8'h55, 1'b1);
    idle(BIT);
    check("f55_count", done_cnt, 1);
    check("f55_data", {24'd0, bus.oData}, 32'h55);
    check("f55_err",  {31'd0, bus.oErr},  32'd0);
    check("f55_latency_ok", (done_cyc - fall_cyc >= 4122 && done_cyc - fall_cyc <= 4130), 1);
    check("f55_done_low", {31'd0, bus.oDone}, 32'd0);

    // Short low glitch rejected at the start-bit sample
    bus.RXD = 1'b0;
    idle(100);
    bus.RXD = 1'b1;
    idle(5000);
    check("glitch_no_done", done_cnt, 1);
    send_byte(8'h3C, 1'b1);
    idle(BIT);
    check("f3c_count", done_cnt, 2);
    check("f3c_data", {24'd0, bus.oData}, 32'h3C);

    // Framing error then recovery
    send_byte(8'hA3, 1'b0);
    idle(2 * BIT);
    check("fa3_count", done_cnt, 3);
    check("fa3_data", {24'd0, bus.oData}, 32'hA3);
    check("fa3_err",  {31'd0, bus.oErr},  32'd1);
    send_byte(8'h01, 1'b1);
    idle(BIT);
    check("f01_data", {24'd0, bus.oData}, 32'h01);
    check("f01_err",  {31'd0, bus.oErr},  32'd0);

    // Back-to-back frames with a single stop bit
    n0 = done_cnt;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    idle(BIT);
    check("b2b_count", done_cnt - n0, 2);
    check("b2b_first",  {24'd0, seen_data[n0]},     32'h00);
    check("b2b_second", {24'd0, seen_data[n0 + 1]}, 32'hFF);

    // Reset pulse during data bit 4 of 0xF0 (bits 4..7 and stop stay high)
    n0 = done_cnt;
    fork
      send_byte(8'hF0, 1'b1);
      begin
        idle(BIT * 5 + BIT / 2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("rst_mid_data", {24'd0, bus.oData}, 32'h00);
        check("rst_mid_err",  {31'd0, bus.oErr},  32'd0);
      end
    join
    idle(2 * BIT);
    check("rst_no_done", done_cnt - n0, 0);
    send_byte(8'h0F, 1'b1);
    idle(BIT);
    check("f0f_count", done_cnt - n0, 1);
    check("f0f_data", {24'd0, bus.oData}, 32'h0F);

    // iCall dropped mid-frame; line after bit 3 of 0x77 has a falling edge, kept disabled to stop sample
    n0 = done_cnt;
    fork
      send_byte(8'h77, 1'b1);
      begin
        idle(BIT * 3);
        bus.iCall = 1'b0;
      end
    join
    idle(BIT);
    check("icall_mid_no_done", done_cnt - n0, 0);
    check("icall_mid_hold", {24'd0, bus.oData}, 32'h0F);

    // Disabled for the whole frame
    send_byte(8'h12, 1'b1);
    idle(BIT);
    check("icall_off_no_done", done_cnt - n0, 0);

    // Enable rising while the line is already low must not start a frame
    bus.RXD = 1'b0;
    idle(50);
    bus.iCall = 1'b1;
    idle(50);
    bus.RXD = 1'b1;
    idle(5000);
    check("icall_low_line_no_done", done_cnt - n0, 0);
    send_byte(8'h81, 1'b1);
    idle(BIT);
    check("f81_count", done_cnt - n0, 1);
    check("f81_data", {24'd0, bus.oData}, 32'h81);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rx_funcmod.md
RX_FUNCMOD -- requirements
Module: rx_funcmod

Interface
REQ-001 Parameter B115K2, default 9'd434, SHALL set clocks per bit: (1/115200)/(1/50E+6).
REQ-002 Parameter HALF, default 9'd217, SHALL set clocks from the detected start edge to the start-bit mid-point.
REQ-003 CLOCK  input  1  SHALL be the single clock, 50 MHz; all logic is on the rising edge.
REQ-004 RESET  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 RXD  input  1  SHALL be the asynchronous serial line: idle high, 8N1, LSB first.
REQ-006 iCall  input  1  SHALL enable reception while high.
REQ-007 oDone  output  1  SHALL pulse high for one clock when a frame completes.
REQ-008 oData  output  8  SHALL hold the last received byte.
REQ-009 oErr  output  1  SHALL flag a framing error for the last completed frame.

Function
REQ-010 RXD SHALL pass through a 2-FF synchronizer; all sampling and edge detection SHALL use the synchronized value only.
REQ-011 FSM states SHALL be HUNT, START, DATA, STOP, DONE.
REQ-012 HUNT: wait for a synchronized 1->0 transition while iCall=1; the detect cycle is E; C1 cleared; go to START.
REQ-013 START: sample at E+HALF; sampled 1 -> glitch, return to HUNT with no output change; sampled 0 -> go to DATA.
REQ-014 DATA: bit k (k=0..7) SHALL be sampled at E+HALF+B115K2*(k+1) into shift register position k, LSB first.
REQ-015 STOP: sample at E+HALF+B115K2*9; sampled 0 sets the error condition.
REQ-016 DONE: the cycle after the stop sample, oData <= shift register, oErr <= (stop==0), oDone=1 for exactly one clock; next state HUNT.
REQ-017 oData and oErr SHALL change only in DONE and SHALL hold otherwise.
REQ-018 Bit counter C1 SHALL count 0..B115K2-1 and wrap to 0 at each sample point; the bit index SHALL count 0..9.
REQ-019 Edges occurring before the stop sample SHALL be ignored; hunting resumes only in HUNT, so back-to-back frames with a 1-bit stop SHALL be received.
REQ-020 iCall=0 in any state other than DONE SHALL force HUNT on the next clock with no oDone; oData and oErr hold.
REQ-021 iCall=0 in DONE SHALL NOT suppress the oDone pulse.
REQ-022 iCall rising while RXD is already low SHALL NOT start a frame; a fresh 1->0 edge is required.

Reset
REQ-023 With RESET=1 at a rising CLOCK: state=HUNT, C1=0, bit index=0, shift register=0, oData=8'h00, oDone=0, oErr=0, both synchronizer stages=1.
REQ-024 Reset mid-frame SHALL abandon the frame with no oDone; reception resumes on the first edge after RESET falls.
REQ-025 RESET SHALL take priority over iCall and all other inputs.

Verification
REQ-026 iCall=1; frame 0x55 at 115200 baud, stop=1 -> one oDone pulse ~E+4124 cycles, oData=8'h55, oErr=0.
REQ-027 RXD low for 100 clocks then high -> no oDone; FSM in HUNT; a following frame 0x3C -> oData=8'h3C.
REQ-028 Frame 0xA3 with stop bit driven 0 -> oDone pulse, oData=8'hA3, oErr=1; next good frame 0x01 -> oErr=0.
REQ-029 Back-to-back frames 0x00 then 0xFF, no idle gap -> two oDone pulses, oData 8'h00 then 8'hFF.
REQ-030 RESET=1 for 1 clock during data bit 4 -> outputs 0, no oDone; next frame 0x0F -> oData=8'h0F.
REQ-031 iCall=0 during frame 0x77 -> no oDone; iCall=0 from the start of a frame -> frame ignored.
